udp_tx_builder: RTL and testbench

// - Transmit-side UDP encapsulator. Accepts a payload byte stream from the application and

---
 rtl/eth_pkg.sv | 17 +
 rtl/udp_tx_builder.sv | 172 +++++++++++++++++
 tb/tb_udp_tx_builder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/IP/UDP stack types and constants.
// Provides byte_t, UDP header length, UDP payload limit and UDP TX FSM states.
package eth_pkg;

    typedef logic [7:0] byte_t;

    localparam int          UDP_HEADER_LEN  = 8;
    localparam logic [15:0] UDP_MAX_PAYLOAD = 16'd65527;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN
    } udp_tx_state_t;

endpackage

// File: rtl/udp_tx_builder.sv
// UDP transmit encapsulator: emits an 8-byte UDP header followed by the app payload.
// Ports: clk/rst (sync, active-high); tx_start/tx_len/tx_busy/tx_len_err (request side);
//   app_data_in/app_byte_valid/app_eof/app_ready (payload in);
//   udp_data_out/udp_byte_valid/udp_eof/udp_err/udp_ready (datagram out, registered).
module udp_tx_builder
    import eth_pkg::*;
#(
    parameter logic [15:0] SRC_PORT  = 16'h1234,
    parameter logic [15:0] DEST_PORT = 16'h1234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [15:0] tx_len,
    output logic        tx_busy,
    output logic        tx_len_err,
    input  byte_t       app_data_in,
    input  logic        app_byte_valid,
    input  logic        app_eof,
    output logic        app_ready,
    output byte_t       udp_data_out,
    output logic        udp_byte_valid,
    output logic        udp_eof,
    output logic        udp_err,
    input  logic        udp_ready
);

    udp_tx_state_t state, state_d;

    logic [15:0] cnt, cnt_d;
    logic [15:0] len_q, len_d;
    byte_t       data_d;
    logic        valid_d, eof_d, err_d, len_err_d;

    logic advance;
    logic app_take;
    logic start_ok;
    logic start_bad;
    logic last;

    function automatic byte_t hdr_byte(input logic [2:0] idx, input logic [15:0] len);
        logic [15:0] ulen;
        ulen = len + 16'(UDP_HEADER_LEN);
        unique case (idx)
            3'd0:    hdr_byte = SRC_PORT[15:8];
            3'd1:    hdr_byte = SRC_PORT[7:0];
            3'd2:    hdr_byte = DEST_PORT[15:8];
            3'd3:    hdr_byte = DEST_PORT[7:0];
            3'd4:    hdr_byte = ulen[15:8];
            3'd5:    hdr_byte = ulen[7:0];
            default: hdr_byte = 8'h00;
        endcase
    endfunction

    // Output register may take a new byte when empty or being drained this cycle.
    assign advance   = !udp_byte_valid || udp_ready;
    assign app_ready = ((state == PAYLOAD) || (state == DRAIN)) && advance;
    assign app_take  = app_byte_valid && app_ready;
    assign start_ok  = (state == IDLE) && tx_start && (tx_len <= UDP_MAX_PAYLOAD);
    assign start_bad = (state == IDLE) && tx_start && (tx_len > UDP_MAX_PAYLOAD);
    assign last      = (cnt == len_q - 16'd1);
    assign tx_busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (start_ok) state_d = HEADER;
            end
            HEADER: begin
                if (advance && cnt[2:0] == 3'd7)
                    state_d = (len_q == 16'd0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                if (app_take) begin
                    if (app_eof)   state_d = IDLE;
                    else if (last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (app_take && app_eof) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt;
        len_d     = len_q;
        data_d    = udp_data_out;
        valid_d   = udp_byte_valid;
        eof_d     = udp_eof;
        err_d     = udp_err;
        len_err_d = 1'b0;
        if (advance) begin
            valid_d = 1'b0;
            eof_d   = 1'b0;
            err_d   = 1'b0;
        end
        unique case (state)
            IDLE: begin
                len_err_d = start_bad;
                if (start_ok) begin
                    len_d = tx_len;
                    cnt_d = 16'd0;
                    // Header byte 0 goes out on the start edge when the register is free.
                    if (advance) begin
                        data_d  = hdr_byte(3'd0, tx_len);
                        valid_d = 1'b1;
                        cnt_d   = 16'd1;
                    end
                end
            end
            HEADER: begin
                if (advance) begin
                    data_d  = hdr_byte(cnt[2:0], len_q);
                    valid_d = 1'b1;
                    if (cnt[2:0] == 3'd7) begin
                        cnt_d = 16'd0;
                        eof_d = (len_q == 16'd0);
                    end else begin
                        cnt_d = cnt + 16'd1;
                    end
                end
            end
            PAYLOAD: begin
                if (app_take) begin
                    data_d  = app_data_in;
                    valid_d = 1'b1;
                    cnt_d   = cnt + 16'd1;
                    if (app_eof) begin
                        eof_d = 1'b1;
                        err_d = !last;
                    end else if (last) begin
                        eof_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= 16'd0;
            len_q          <= 16'd0;
            udp_data_out   <= 8'h00;
            udp_byte_valid <= 1'b0;
            udp_eof        <= 1'b0;
            udp_err        <= 1'b0;
            tx_len_err     <= 1'b0;
        end else begin
            cnt            <= cnt_d;
            len_q          <= len_d;
            udp_data_out   <= data_d;
            udp_byte_valid <= valid_d;
            udp_eof        <= eof_d;
            udp_err        <= err_d;
            tx_len_err     <= len_err_d;
        end
    end

endmodule

// File: tb/tb_udp_tx_builder.sv
// Scoreboard bench for udp_tx_builder.
// Stimulus pushes expected bytes; a negedge monitor pops and compares.
module tb_udp_tx_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_start = 1'b0;
    logic [15:0] tx_len = 16'd0;
    logic        tx_busy;
    logic        tx_len_err;
    logic [7:0]  app_data_in = 8'h00;
    logic        app_byte_valid = 1'b0;
    logic        app_eof = 1'b0;
    logic        app_ready;
    logic [7:0]  udp_data_out;
    logic        udp_byte_valid;
    logic        udp_eof;
    logic        udp_err;
    logic        udp_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;
    int app_rdy_cnt = 0;

    logic [9:0] sb[$];
    logic [7:0] pq[$];

    udp_tx_builder dut (
        .clk            (clk),
        .rst            (rst),
        .tx_start       (tx_start),
        .tx_len         (tx_len),
        .tx_busy        (tx_busy),
        .tx_len_err     (tx_len_err),
        .app_data_in    (app_data_in),
        .app_byte_valid (app_byte_valid),
        .app_eof        (app_eof),
        .app_ready      (app_ready),
        .udp_data_out   (udp_data_out),
        .udp_byte_valid (udp_byte_valid),
        .udp_eof        (udp_eof),
        .udp_err        (udp_err),
        .udp_ready      (udp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            udp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops on every transfer, checks hold stability while stalled.
    initial begin
        logic       held;
        logic [9:0] held_v;
        logic [9:0] exp_v;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            if (app_ready) app_rdy_cnt++;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held)
                    chk("hold_stable", {21'd0, udp_byte_valid, udp_err, udp_eof, udp_data_out},
                        {21'd0, 1'b1, held_v});
                if (udp_byte_valid && udp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte actual=%h required=none", udp_data_out);
                    end else begin
                        exp_v = sb.pop_front();
                        chk("out_byte", {22'd0, udp_err, udp_eof, udp_data_out}, {22'd0, exp_v});
                    end
                end
                held = udp_byte_valid && !udp_ready;
                held_v = {udp_err, udp_eof, udp_data_out};
            end
        end
    end

    // Expected datagram for declared length len and n app bytes (eof on last if eof_last).
    task automatic expect_dgram(input int len, input int n, input bit eof_last);
        logic [15:0] ul;
        bit e;
        bit r;
        ul = 16'(len + 8);
        sb.push_back({2'b00, 8'h12});
        sb.push_back({2'b00, 8'h34});
        sb.push_back({2'b00, 8'h12});
        sb.push_back({2'b00, 8'h34});
        sb.push_back({2'b00, ul[15:8]});
        sb.push_back({2'b00, ul[7:0]});
        sb.push_back({2'b00, 8'h00});
        sb.push_back({1'b0, (len == 0), 8'h00});
        if (len > 0) begin
            for (int i = 0; i < n; i++) begin
                e = (eof_last && i == n - 1) || (i == len - 1);
                r = e && !(eof_last && i == n - 1 && i == len - 1);
                sb.push_back({r, e, pq[i]});
                if (e) break;
            end
        end
    endtask

    task automatic start_dgram(input logic [15:0] len);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx_busy && k < 3000);
        if (tx_busy) chk("start_wait_timeout", 1, 0);
        tx_len = len;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic send_app(input bit eof_last, input bit gaps);
        bit acc;
        int k;
        for (int i = 0; i < pq.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                app_byte_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            app_byte_valid = 1'b1;
            app_data_in = pq[i];
            app_eof = eof_last && (i == pq.size() - 1);
            k = 0;
            do begin
                @(negedge clk);
                acc = app_ready;
                @(posedge clk);
                #1;
                k++;
            end while (!acc && k < 2000);
            if (!acc) begin
                chk("app_accept_timeout", 0, 1);
                break;
            end
        end
        app_byte_valid = 1'b0;
        app_eof = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !tx_busy && !udp_byte_valid) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int rc0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outs", {26'd0, tx_busy, tx_len_err, app_ready, udp_byte_valid, udp_eof, udp_err},
            32'd0);

        // Basic 4-byte datagram, checked for start latency.
        pq = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        expect_dgram(4, 4, 1'b1);
        start_dgram(16'd4);
        chk("latency1", {23'd0, udp_byte_valid, udp_data_out}, {23'd0, 1'b1, 8'h12});
        send_app(1'b1, 1'b0);
        wait_done();
        chk("busy_low_after", {31'd0, tx_busy}, 32'd0);

        // Empty payload.
        rc0 = app_rdy_cnt;
        pq = {};
        expect_dgram(0, 0, 1'b0);
        start_dgram(16'd0);
        wait_done();
        chk("len0_no_app_ready", app_rdy_cnt - rc0, 32'd0);

        // Short payload, then long payload back to back.
        pq = {8'h11, 8'h22};
        expect_dgram(3, 2, 1'b1);
        start_dgram(16'd3);
        send_app(1'b1, 1'b0);
        pq = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        expect_dgram(2, 5, 1'b1);
        start_dgram(16'd2);
        send_app(1'b1, 1'b0);
        wait_done();

        // Oversized length is rejected.
        start_dgram(16'd65528);
        chk("len_err_pulse", {30'd0, tx_len_err, tx_busy}, {30'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        chk("len_err_clear", {29'd0, tx_len_err, tx_busy, udp_byte_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("len_err_no_out", sb.size(), 0);

        // 64-byte payload with stalls and gaps.
        rand_rdy = 1'b1;
        pq = {};
        for (int i = 0; i < 64; i++) pq.push_back(8'(i * 7 + 3));
        expect_dgram(64, 64, 1'b1);
        start_dgram(16'd64);
        send_app(1'b1, 1'b1);
        wait_done();

        // Reset in the middle of a payload.
        pq = {};
        for (int i = 0; i < 10; i++) pq.push_back(8'(8'hC0 + i));
        expect_dgram(64, 10, 1'b0);
        start_dgram(16'd64);
        send_app(1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_outs", {18'd0, tx_busy, tx_len_err, app_ready, udp_byte_valid, udp_eof,
            udp_err, udp_data_out}, 32'd0);
        rst = 1'b0;
        sb.delete();
        rand_rdy = 1'b0;

        // Recovery after reset.
        pq = {8'h5A};
        expect_dgram(1, 1, 1'b1);
        start_dgram(16'd1);
        send_app(1'b1, 1'b0);
        wait_done();
        chk("sb_empty_end", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
